// File: rtl/fft_buf_pkg.sv
// Shared definitions for the FFT ping-pong frame buffer: default sizes,
// read FSM state encoding and the bit-reversal helper.
package fft_buf_pkg;

  localparam int N_LOG2_DEF = 13;
  localparam int N_DEF      = 1 << N_LOG2_DEF;
  localparam int DW_DEF     = 36;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } rd_state_t;

  // Reverse the low n bits of v; bits above n come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int n);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < 16; i++) begin
      if (i < n) begin
        r = {r[14:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_buf_bank.sv
// One frame bank: simple dual-port RAM, N x DW, one write port and one read
// port with a single registered output stage (maps onto block RAM).
module fft_buf_bank #(
  parameter int N_LOG2 = 13,
  parameter int DW     = 36
) (
  input  logic              clk,
  input  logic              we,
  input  logic [N_LOG2-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              re,
  input  logic [N_LOG2-1:0] raddr,
  output logic [DW-1:0]     rdata_p1
);

  logic [DW-1:0] mem [0:(1<<N_LOG2)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; output holds while re is low
  always_ff @(posedge clk) begin
    if (re) rdata_p1 <= mem[raddr];
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer between the float32->float18 converter and the FFT
// core. Collects N-point frames of packed {re18,im18} samples into two banks
// and streams each complete frame out with valid/ready plus sof/eof markers.
// Build option: define FFT_BUF_BITREV_EN to emit each frame in bit-reversed
// address order (sof/eof still mark the first/last emitted word).
module fft_frame_buffer
  import fft_buf_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_vld,
  input  logic [DW-1:0] din,
  output logic          dout_vld,
  input  logic          dout_rdy,
  output logic [DW-1:0] dout,
  output logic          dout_sof,
  output logic          dout_eof,
  output logic          overflow,
  output logic [15:0]   frm_cnt
);

  localparam logic [N_LOG2-1:0] LAST_IDX = '1;

  // ---------------- write side ----------------
  logic [N_LOG2-1:0] wr_ptr;
  logic              wr_bank;
  logic [1:0]        full;
  logic              wr_en;
  logic              wr_last;

  // Read side signals referenced by the shared full flags
  rd_state_t         state, nstate;
  logic              rd_bank;
  logic              rd_en;
  logic [N_LOG2-1:0] rd_idx;
  logic [N_LOG2-1:0] rd_addr;
  logic [N_LOG2-1:0] iss_cnt;
  logic              iss_done;
  logic              rd_last_hs;

  assign wr_en   = din_vld & ~full[wr_bank];
  assign wr_last = wr_en & (wr_ptr == LAST_IDX);

  // Write pointer and bank select; pointer wraps to 0 on the last point
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (wr_ptr == LAST_IDX) wr_bank <= ~wr_bank;
    end
  end

  // Sticky overflow: a sample arrived while the target bank was still full
  always_ff @(posedge clk) begin
    if (rst)                          overflow <= 1'b0;
    else if (din_vld & full[wr_bank]) overflow <= 1'b1;
  end

  // Bank full flags: set by the writer's last point, cleared by the reader's
  // last handshake; the two always address different banks
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (wr_last)    full[wr_bank] <= 1'b1;
      if (rd_last_hs) full[rd_bank] <= 1'b0;
    end
  end

  // ---------------- RAM banks ----------------
  logic [DW-1:0] q0_p1, q1_p1;

  fft_buf_bank #(.N_LOG2(N_LOG2), .DW(DW)) u_bank0 (
    .clk      (clk),
    .we       (wr_en & ~wr_bank),
    .waddr    (wr_ptr),
    .wdata    (din),
    .re       (rd_en & ~rd_bank),
    .raddr    (rd_addr),
    .rdata_p1 (q0_p1)
  );

  fft_buf_bank #(.N_LOG2(N_LOG2), .DW(DW)) u_bank1 (
    .clk      (clk),
    .we       (wr_en & wr_bank),
    .waddr    (wr_ptr),
    .wdata    (din),
    .re       (rd_en & rd_bank),
    .raddr    (rd_addr),
    .rdata_p1 (q1_p1)
  );

`ifdef FFT_BUF_BITREV_EN
  logic [15:0] rev_idx;
  assign rev_idx = bitrev(16'(rd_idx), N_LOG2);
  assign rd_addr = rev_idx[N_LOG2-1:0];
`else
  assign rd_addr = rd_idx;
`endif

  // ---------------- output skid (p1 = RAM register, b = side slot) ----------------
  logic          vld_p1, sof_p1, eof_p1;
  logic          vld_b, sof_b, eof_b;
  logic [DW-1:0] dat_b;
  logic [DW-1:0] ram_q;
  logic          head_vld, head_sof, head_eof;
  logic [DW-1:0] head_dat;
  logic          pop, skid_space, b_load;
  logic          sof_new, eof_new;

  // All in-flight words of a frame come from rd_bank; the pipe is empty
  // whenever rd_bank toggles.
  assign ram_q      = rd_bank ? q1_p1 : q0_p1;
  assign head_vld   = vld_b | vld_p1;
  assign head_dat   = vld_b ? dat_b : ram_q;
  assign head_sof   = vld_b ? sof_b : sof_p1;
  assign head_eof   = vld_b ? eof_b : eof_p1;
  assign pop        = head_vld & dout_rdy;
  assign skid_space = ~(vld_p1 & vld_b) | pop;
  assign rd_last_hs = pop & head_eof;
  assign sof_new    = (rd_idx == '0);
  assign eof_new    = (rd_idx == LAST_IDX);
  // Park the RAM word in the side slot when a new read would overwrite it
  assign b_load     = rd_en & vld_p1 & (vld_b ? pop : ~pop);

  // Skid control and marker tags
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      eof_p1 <= 1'b0;
      vld_b  <= 1'b0;
      sof_b  <= 1'b0;
      eof_b  <= 1'b0;
    end else begin
      if (rd_en) begin
        vld_p1 <= 1'b1;
        sof_p1 <= sof_new;
        eof_p1 <= eof_new;
      end else if (pop & ~vld_b) begin
        vld_p1 <= 1'b0;
      end
      if (b_load) begin
        vld_b <= 1'b1;
        sof_b <= sof_p1;
        eof_b <= eof_p1;
      end else if (pop & vld_b) begin
        vld_b <= 1'b0;
      end
    end
  end

  // Side-slot data
  always_ff @(posedge clk) begin
    if (b_load) dat_b <= ram_q;
  end

  assign dout_vld = head_vld;
  assign dout     = head_vld ? head_dat : '0;
  assign dout_sof = head_vld & head_sof;
  assign dout_eof = head_vld & head_eof;

  // ---------------- read FSM ----------------
  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (full[rd_bank]) nstate = FETCH;
      FETCH:   nstate = STREAM;
      STREAM:  if (rd_last_hs) nstate = full[~rd_bank] ? FETCH : IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Read issue: point 0 in FETCH, then one point per cycle while skid has room
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = '0;
    case (state)
      FETCH:  rd_en = 1'b1;
      STREAM: begin
        rd_en  = ~iss_done & skid_space;
        rd_idx = iss_cnt;
      end
      default: ;
    endcase
  end

  // Read counter for the frame being issued
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_cnt  <= '0;
      iss_done <= 1'b0;
    end else if (state == FETCH) begin
      iss_cnt  <= N_LOG2'(1);
      iss_done <= 1'b0;
    end else if ((state == STREAM) && rd_en) begin
      iss_cnt <= iss_cnt + 1'b1;
      if (iss_cnt == LAST_IDX) iss_done <= 1'b1;
    end
  end

  // Reader bank and delivered-frame count advance on the last handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank <= 1'b0;
      frm_cnt <= '0;
    end else if (rd_last_hs) begin
      rd_bank <= ~rd_bank;
      frm_cnt <= frm_cnt + 16'd1;
    end
  end

endmodule
